// File: rtl/barrett_pkg.sv
// Shared Barrett definitions: FSM states, default modulus width and the
// derived mu / k widths, used by the mu generator and the reduction datapath.
package barrett_pkg;

   localparam int Q_W_DEF = 64;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      NORM = 2'd1,
      DIV  = 2'd2,
      DONE = 2'd3
   } barrett_state_t;

   // mu peaks at 2^(k+1) when q is a power of two, so it needs two extra bits
   function automatic int mu_width(input int qw);
      return qw + 2;
   endfunction

   function automatic int k_width(input int qw);
      return $clog2(qw + 1);
   endfunction

endpackage

// File: rtl/barrett_lzc.sv
// Combinational bit-length of q: k = Q_W - lzc(q), zero when q is zero.
module barrett_lzc
   import barrett_pkg::*;
#(
   parameter int Q_W = Q_W_DEF,
   parameter int K_W = k_width(Q_W)
) (
   input  logic [Q_W-1:0] q,
   output logic [K_W-1:0] k
);

   // highest set bit wins, scanning upward
   always_comb begin
      k = {K_W{1'b0}};
      for (int b = 0; b < Q_W; b++) begin
         k = q[b] ? K_W'(b + 32'sd1) : k;
      end
   end

endmodule

// File: rtl/barrett_mu_gen.sv
// Sequential Barrett constant generator: mu = floor(2^(2k)/q) and k = bitlen(q),
// restoring division one quotient bit per cycle. Macro BARRETT_MU_REM_EN exports rem.
module barrett_mu_gen
   import barrett_pkg::*;
#(
   parameter int Q_W  = Q_W_DEF,
   parameter int MU_W = mu_width(Q_W),
   parameter int K_W  = k_width(Q_W)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [Q_W-1:0]  q,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [MU_W-1:0] mu,
   output logic [K_W-1:0]  k,
   output logic            err
`ifdef BARRETT_MU_REM_EN
   ,
   output logic [Q_W-1:0]  rem
`endif
);

   localparam logic [K_W:0]  I_ZERO  = {(K_W+1){1'b0}};
   localparam logic [K_W:0]  I_ONE   = {{K_W{1'b0}}, 1'b1};
   localparam logic [Q_W-1:0] Q_ZERO = {Q_W{1'b0}};
   localparam logic [MU_W-1:0] MU_ZERO = {MU_W{1'b0}};

   barrett_state_t    state_r;
   logic [Q_W-1:0]    q_r;
   logic [Q_W-1:0]    r_r;
   logic [MU_W-1:0]   qt_r;
   logic [K_W:0]      i_r;
   logic [K_W-1:0]    k_r;
   logic              in_ready_r;
   logic              out_valid_r;
   logic              err_r;

   logic [K_W-1:0]    lzc_k_s;
   logic [Q_W:0]      r_sh_s;
   logic [Q_W:0]      diff_s;
   logic              ge_s;
   logic [Q_W-1:0]    r_nx_s;
   logic [MU_W-1:0]   qt_nx_s;

   barrett_lzc #(.Q_W(Q_W), .K_W(K_W)) u_lzc (
      .q (q_r),
      .k (lzc_k_s)
   );

   // One restoring step. R < q always, so R fits Q_W bits and the shifted
   // R' needs Q_W+1; R' >= q when R' overflowed Q_W bits or R'-q did not borrow.
   always_comb begin
      r_sh_s  = {r_r, (i_r == {k_r, 1'b0})};
      diff_s  = r_sh_s - {1'b0, q_r};
      ge_s    = r_sh_s[Q_W] | ~diff_s[Q_W];
      if (ge_s) begin
         r_nx_s = diff_s[Q_W-1:0];
      end else begin
         r_nx_s = r_sh_s[Q_W-1:0];
      end
      qt_nx_s = {qt_r[MU_W-2:0], ge_s};
   end

   // Control FSM with registered handshake and result outputs
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_r     <= IDLE;
         q_r         <= Q_ZERO;
         r_r         <= Q_ZERO;
         qt_r        <= MU_ZERO;
         i_r         <= I_ZERO;
         k_r         <= {K_W{1'b0}};
         in_ready_r  <= 1'b0;
         out_valid_r <= 1'b0;
         err_r       <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (in_valid && in_ready_r) begin
                  q_r        <= q;
                  in_ready_r <= 1'b0;
                  state_r    <= NORM;
               end else begin
                  in_ready_r <= 1'b1;
               end
            end
            NORM: begin
               k_r  <= lzc_k_s;
               r_r  <= Q_ZERO;
               qt_r <= MU_ZERO;
               if (q_r == Q_ZERO) begin
                  err_r       <= 1'b1;
                  out_valid_r <= 1'b1;
                  state_r     <= DONE;
               end else begin
                  i_r     <= {lzc_k_s, 1'b0};
                  state_r <= DIV;
               end
            end
            DIV: begin
               r_r  <= r_nx_s;
               qt_r <= qt_nx_s;
               if (i_r == I_ZERO) begin
                  out_valid_r <= 1'b1;
                  state_r     <= DONE;
               end else begin
                  i_r <= i_r - I_ONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid_r <= 1'b0;
                  err_r       <= 1'b0;
                  in_ready_r  <= 1'b1;
                  state_r     <= IDLE;
               end else begin
                  out_valid_r <= 1'b1;
               end
            end
            default: begin
               in_ready_r  <= 1'b0;
               out_valid_r <= 1'b0;
               state_r     <= IDLE;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_r;
   assign out_valid = out_valid_r;
   assign mu        = qt_r;
   assign k         = k_r;
   assign err       = err_r;
`ifdef BARRETT_MU_REM_EN
   assign rem       = r_r;
`endif

endmodule

// File: tb/tb_barrett_mu_gen.sv
// Self-checking bench for barrett_mu_gen: directed and random moduli against
// an arithmetic reference (wide divide), plus latency, back-pressure and reset checks.
module tb_barrett_mu_gen;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [63:0] q = 64'd0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [65:0] mu;
   logic [6:0]  k;
   logic        err;
`ifdef BARRETT_MU_REM_EN
   logic [63:0] rem;
`endif

   int nvec = 0;
   int nerr = 0;

   barrett_mu_gen dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .q         (q),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .mu        (mu),
      .k         (k),
      .err       (err)
`ifdef BARRETT_MU_REM_EN
      ,
      .rem       (rem)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [129:0] obs, input logic [129:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: k is the bit length of q, mu and rem come from a 130-bit divide of 2^(2k)
   task automatic ref_model(input logic [63:0] qv, output int kk, output logic [65:0] m,
                            output logic [63:0] r, output logic e);
      logic [129:0] dvd;
      kk = 0;
      for (int b = 0; b < 64; b++) if (qv[b]) kk = b + 1;
      if (qv == 64'd0) begin
         m = 66'd0; r = 64'd0; e = 1'b1;
      end else begin
         dvd = 130'd1 << (2 * kk);
         m = 66'(dvd / {66'd0, qv});
         r = 64'(dvd % {66'd0, qv});
         e = 1'b0;
      end
   endtask

   // One transaction: hold = cycles of out_ready low in DONE, poke = spurious q=5 during DIV
   task automatic run_q(input string tag, input logic [63:0] qv, input int hold, input bit poke);
      int kk, n, w, explat;
      logic [65:0] em;
      logic [63:0] er;
      logic ee;
      logic [75:0] snap;
      ref_model(qv, kk, em, er, ee);
      explat = (qv == 64'd0) ? 2 : 2 * kk + 3;
      @(negedge clk);
      out_ready = (hold == 0);
      q = qv;
      in_valid = 1'b1;
      w = 0;
      while (!in_ready && w < 20) begin
         @(negedge clk);
         w++;
      end
      chk({tag, ".in_ready"}, in_ready, 1'b1);
      @(negedge clk);
      in_valid = 1'b0;
      n = 1;
      while (!out_valid && n < 300) begin
         if (poke && n == 5) begin
            chk({tag, ".busy"}, in_ready, 1'b0);
            q = 64'd5;
            in_valid = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
         @(negedge clk);
         n++;
      end
      in_valid = 1'b0;
      chk({tag, ".latency"}, n, explat);
      chk({tag, ".mu"}, mu, em);
      chk({tag, ".k"}, k, kk);
      chk({tag, ".err"}, err, ee);
`ifdef BARRETT_MU_REM_EN
      chk({tag, ".rem"}, rem, er);
`endif
      snap = {1'b1, 1'b0, em, 7'(kk), ee};
      for (int c = 0; c < hold; c++) begin
         @(negedge clk);
         chk({tag, ".hold"}, {out_valid, in_ready, mu, k, err}, snap);
      end
      out_ready = 1'b1;
      @(negedge clk);
      chk({tag, ".release"}, {out_valid, in_ready, err}, 3'b010);
   endtask

   initial begin
      logic [63:0] rq;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset", {in_ready, out_valid, mu, k, err}, 76'd0);
      rst = 1'b1;
      @(negedge clk);
      chk("reset_release", {in_ready, out_valid}, 2'b10);

      run_q("q7681", 64'd7681, 0, 1'b0);
      run_q("q1", 64'd1, 0, 1'b0);
      run_q("q2p63", 64'h8000_0000_0000_0000, 0, 1'b0);
      run_q("qmax", 64'hFFFF_FFFF_FFFF_FFFF, 0, 1'b0);
      run_q("qzero", 64'd0, 0, 1'b0);
      run_q("q7681b", 64'd7681, 0, 1'b0);
      run_q("backpress", 64'd12289, 10, 1'b1);

      // reset in the middle of a division
      @(negedge clk);
      q = 64'hDEAD_BEEF_1234_5678;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (10) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("middiv_reset", {in_ready, out_valid, mu, k, err}, 76'd0);
      rst = 1'b1;
      @(negedge clk);
      chk("middiv_release", {in_ready, out_valid}, 2'b10);
      run_q("q3", 64'd3, 0, 1'b0);

      for (int t = 0; t < 8; t++) begin
         rq = {$urandom, $urandom};
         rq = rq >> $urandom_range(0, 63);
         run_q("rand", rq, (t % 3 == 0) ? 2 : 0, 1'b0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
